// File: rtl/mem_access_unit.sv
// Purpose: MEM-stage access unit; maps byte/half/word loads and stores onto a word-wide big-endian data memory.
// Latency: loads 1 cycle (registered result), word stores 0 cycles, sub-word stores 2 cycles (read then write).
// Backpressure: stall is high only in the read cycle of a sub-word store; bad requests fault without stalling.
module mem_access_unit #(
  parameter int DATA_MEM_SIZE = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        fault,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_write,
  output logic        dm_read,
  input  logic [31:0] dm_rdata
);

  typedef enum logic {
    IDLE = 1'b0,
    RMW  = 1'b1
  } state_t;

  localparam logic [1:0]  SizeByte  = 2'b00;
  localparam logic [1:0]  SizeHalf  = 2'b01;
  localparam logic [1:0]  SizeWord  = 2'b10;
  localparam logic [31:0] MemSize   = 32'(DATA_MEM_SIZE);
  localparam logic [31:0] WordLimit = 32'(DATA_MEM_SIZE - 4);

  state_t      state;
  state_t      nextState;
  logic        badReq;
  logic        acceptReq;
  logic        subWordStore;
  logic [31:0] wordAddr;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic [31:0] loadExt;
  logic [31:0] mergeNext;
  logic [31:0] merge;
  logic [31:0] rmwAddr;

  assign wordAddr     = {req_addr[31:2], 2'b00};
  assign acceptReq    = (state == IDLE) && req_valid && !badReq;
  assign subWordStore = req_write && (req_size != SizeWord);

  // Classify the request: illegal size, misalignment or out-of-range address.
  always_comb begin
    badReq = 1'b0;
    case (req_size)
      SizeByte: badReq = (req_addr >= MemSize);
      SizeHalf: badReq = req_addr[0] || (req_addr >= MemSize);
      SizeWord: badReq = (req_addr[1:0] != 2'b00) || (req_addr > WordLimit);
      default:  badReq = 1'b1;
    endcase
  end

  // Pick the big-endian lane for loads, extend it, and build the merged word for sub-word stores.
  always_comb begin
    laneByte  = 8'h00;
    loadExt   = dm_rdata;
    mergeNext = dm_rdata;
    case (req_addr[1:0])
      2'd0:    laneByte = dm_rdata[31:24];
      2'd1:    laneByte = dm_rdata[23:16];
      2'd2:    laneByte = dm_rdata[15:8];
      default: laneByte = dm_rdata[7:0];
    endcase
    laneHalf = req_addr[1] ? dm_rdata[15:0] : dm_rdata[31:16];
    case (req_size)
      SizeByte: begin
        loadExt = {{24{req_signed & laneByte[7]}}, laneByte};
        case (req_addr[1:0])
          2'd0:    mergeNext[31:24] = req_wdata[7:0];
          2'd1:    mergeNext[23:16] = req_wdata[7:0];
          2'd2:    mergeNext[15:8]  = req_wdata[7:0];
          default: mergeNext[7:0]   = req_wdata[7:0];
        endcase
      end
      SizeHalf: begin
        loadExt = {{16{req_signed & laneHalf[15]}}, laneHalf};
        if (req_addr[1]) mergeNext[15:0] = req_wdata[15:0];
        else             mergeNext[31:16] = req_wdata[15:0];
      end
      default: ;
    endcase
  end

  // Next state and memory-side controls; reset forces every enable low so an RMW write is aborted.
  always_comb begin
    nextState = state;
    stall     = 1'b0;
    dm_addr   = 32'h0;
    dm_wdata  = 32'h0;
    dm_write  = 1'b0;
    dm_read   = 1'b0;
    if (rst) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (acceptReq) begin
            dm_addr = wordAddr;
            if (!req_write) begin
              dm_read = 1'b1;
            end else if (!subWordStore) begin
              dm_write = 1'b1;
              dm_wdata = req_wdata;
            end else begin
              dm_read   = 1'b1;
              stall     = 1'b1;
              nextState = RMW;
            end
          end
        end
        RMW: begin
          dm_write  = 1'b1;
          dm_addr   = rmwAddr;
          dm_wdata  = merge;
          nextState = IDLE;
        end
        default: nextState = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Load result, one-cycle status pulses and the RMW merge buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_data  <= 32'h0;
      load_valid <= 1'b0;
      fault      <= 1'b0;
      merge      <= 32'h0;
      rmwAddr    <= 32'h0;
    end else begin
      load_valid <= 1'b0;
      fault      <= 1'b0;
      if (state == IDLE && req_valid) begin
        if (badReq) begin
          fault <= 1'b1;
        end else if (!req_write) begin
          load_data  <= loadExt;
          load_valid <= 1'b1;
        end else if (subWordStore) begin
          merge   <= mergeNext;
          rmwAddr <= wordAddr;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose: directed bench for mem_access_unit with a behavioural big-endian word memory.
// Latency: checks comb outputs mid-cycle and registered outputs in the following cycle.
// Backpressure: RMW stall, back-to-back requests and reset during RMW are hand-sequenced.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        fault;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_write;
  logic        dm_read;
  logic [31:0] dm_rdata;

  logic [31:0] mem [0:31];

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        eRead;
    logic        eWrite;
    logic [31:0] eAddr;
    logic        eLv;
    logic        eFault;
    logic [31:0] eLd;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  mem_access_unit #(.DATA_MEM_SIZE(128)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .load_data(load_data),
    .load_valid(load_valid), .fault(fault), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_write(dm_write), .dm_read(dm_read),
    .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  assign dm_rdata = mem[dm_addr[6:2]];

  // Reads and writes never share a cycle, so a blocking write here cannot race the DUT capture.
  always @(posedge clk) begin
    if (dm_write) mem[dm_addr[6:2]] = dm_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic setReq(input logic v, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d);
    req_valid  = v;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = d;
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic eR, input logic eW, input logic [31:0] eA,
                              input logic eLv, input logic eF, input logic [31:0] eLd);
    vec_t v;
    v.wr = wr; v.sz = sz; v.sg = sg; v.addr = a; v.wdata = d;
    v.eRead = eR; v.eWrite = eW; v.eAddr = eA;
    v.eLv = eLv; v.eFault = eF; v.eLd = eLd;
    return v;
  endfunction

  initial begin
    //                wr  sz     sg  addr   wdata         rd  wr  dmAddr  lv  flt load_data
    vecs[0]  = mk(1, 2'b10, 0, 32'h10, 32'h80FF1234, 0, 1, 32'h10, 0, 0, 32'h00000000);
    vecs[1]  = mk(1, 2'b10, 0, 32'h7C, 32'h11223344, 0, 1, 32'h7C, 0, 0, 32'h00000000);
    vecs[2]  = mk(0, 2'b10, 0, 32'h10, 32'h0,        1, 0, 32'h10, 1, 0, 32'h80FF1234);
    vecs[3]  = mk(0, 2'b00, 1, 32'h11, 32'h0,        1, 0, 32'h10, 1, 0, 32'hFFFFFFFF);
    vecs[4]  = mk(0, 2'b00, 0, 32'h11, 32'h0,        1, 0, 32'h10, 1, 0, 32'h000000FF);
    vecs[5]  = mk(0, 2'b00, 1, 32'h13, 32'h0,        1, 0, 32'h10, 1, 0, 32'h00000034);
    vecs[6]  = mk(0, 2'b00, 0, 32'h10, 32'h0,        1, 0, 32'h10, 1, 0, 32'h00000080);
    vecs[7]  = mk(0, 2'b00, 1, 32'h12, 32'h0,        1, 0, 32'h10, 1, 0, 32'h00000012);
    vecs[8]  = mk(0, 2'b01, 1, 32'h10, 32'h0,        1, 0, 32'h10, 1, 0, 32'hFFFF80FF);
    vecs[9]  = mk(0, 2'b01, 0, 32'h12, 32'h0,        1, 0, 32'h10, 1, 0, 32'h00001234);
    vecs[10] = mk(0, 2'b01, 1, 32'h11, 32'h0,        0, 0, 32'h0,  0, 1, 32'h00001234);
    vecs[11] = mk(0, 2'b10, 0, 32'h12, 32'h0,        0, 0, 32'h0,  0, 1, 32'h00001234);
    vecs[12] = mk(0, 2'b10, 0, 32'h7D, 32'h0,        0, 0, 32'h0,  0, 1, 32'h00001234);
    vecs[13] = mk(1, 2'b00, 0, 32'h80, 32'h77,       0, 0, 32'h0,  0, 1, 32'h00001234);
    vecs[14] = mk(0, 2'b11, 0, 32'h10, 32'h0,        0, 0, 32'h0,  0, 1, 32'h00001234);
    vecs[15] = mk(0, 2'b10, 0, 32'h80, 32'h0,        0, 0, 32'h0,  0, 1, 32'h00001234);
    vecs[16] = mk(0, 2'b10, 0, 32'h7C, 32'h0,        1, 0, 32'h7C, 1, 0, 32'h11223344);
    vecs[17] = mk(0, 2'b00, 0, 32'h7F, 32'h0,        1, 0, 32'h7C, 1, 0, 32'h00000044);
    vecs[18] = mk(0, 2'b01, 1, 32'h7E, 32'h0,        1, 0, 32'h7C, 1, 0, 32'h00003344);
    vecs[19] = mk(0, 2'b00, 1, 32'h7C, 32'h0,        1, 0, 32'h7C, 1, 0, 32'h00000011);
    vecs[20] = mk(0, 2'b00, 0, 32'h80, 32'h0,        0, 0, 32'h0,  0, 1, 32'h00000011);

    for (int i = 0; i < 32; i++) mem[i] = 32'h0;

    // Reset with a word store presented: memory enables must stay low.
    rst = 1'b1;
    setReq(1, 1, 2'b10, 0, 32'h20, 32'h5A5A5A5A);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkBit("rst_dm_write", dm_write, 1'b0);
    checkBit("rst_dm_read", dm_read, 1'b0);
    checkBit("rst_stall", stall, 1'b0);
    checkBit("rst_load_valid", load_valid, 1'b0);
    checkBit("rst_fault", fault, 1'b0);
    check("rst_load_data", load_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    setReq(0, 0, 2'b00, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("rst_mem_untouched", mem[8], 32'h0);
    checkBit("idle_dm_write", dm_write, 1'b0);
    checkBit("idle_dm_read", dm_read, 1'b0);

    // Single-cycle requests from the table.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      setReq(1, vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      checkBit($sformatf("v%0d_lv_cleared", i), load_valid, 1'b0);
      checkBit($sformatf("v%0d_fault_cleared", i), fault, 1'b0);
      checkBit($sformatf("v%0d_stall", i), stall, 1'b0);
      checkBit($sformatf("v%0d_dm_read", i), dm_read, vecs[i].eRead);
      checkBit($sformatf("v%0d_dm_write", i), dm_write, vecs[i].eWrite);
      check($sformatf("v%0d_dm_addr", i), dm_addr, vecs[i].eAddr);
      if (vecs[i].eWrite) check($sformatf("v%0d_dm_wdata", i), dm_wdata, vecs[i].wdata);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      checkBit($sformatf("v%0d_load_valid", i), load_valid, vecs[i].eLv);
      checkBit($sformatf("v%0d_fault", i), fault, vecs[i].eFault);
      check($sformatf("v%0d_load_data", i), load_data, vecs[i].eLd);
    end

    // Byte store RMW into 0x80FF1234.
    @(posedge clk); #1;
    setReq(1, 1, 2'b00, 0, 32'h12, 32'h000000AB);
    @(negedge clk);
    checkBit("sb_c1_stall", stall, 1'b1);
    checkBit("sb_c1_dm_read", dm_read, 1'b1);
    checkBit("sb_c1_dm_write", dm_write, 1'b0);
    check("sb_c1_dm_addr", dm_addr, 32'h10);
    @(posedge clk); #1;
    @(negedge clk);
    checkBit("sb_c2_stall", stall, 1'b0);
    checkBit("sb_c2_dm_write", dm_write, 1'b1);
    checkBit("sb_c2_dm_read", dm_read, 1'b0);
    check("sb_c2_dm_addr", dm_addr, 32'h10);
    check("sb_c2_dm_wdata", dm_wdata, 32'h80FFAB34);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("sb_mem", mem[4], 32'h80FFAB34);
    checkBit("sb_no_lv", load_valid, 1'b0);

    // Restore the word, halfword store RMW, then a word store straight after.
    @(posedge clk); #1;
    setReq(1, 1, 2'b10, 0, 32'h10, 32'h80FF1234);
    @(posedge clk); #1;
    setReq(1, 1, 2'b01, 0, 32'h10, 32'hFFFFCAFE);
    @(negedge clk);
    checkBit("sh_c1_stall", stall, 1'b1);
    checkBit("sh_c1_dm_read", dm_read, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    checkBit("sh_c2_dm_write", dm_write, 1'b1);
    check("sh_c2_dm_wdata", dm_wdata, 32'hCAFE1234);
    @(posedge clk); #1;
    setReq(1, 1, 2'b10, 0, 32'h14, 32'hDEADBEEF);
    @(negedge clk);
    checkBit("sw_after_rmw_write", dm_write, 1'b1);
    checkBit("sw_after_rmw_stall", stall, 1'b0);
    check("sw_after_rmw_addr", dm_addr, 32'h14);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("sh_mem", mem[4], 32'hCAFE1234);
    check("sw_after_rmw_mem", mem[5], 32'hDEADBEEF);

    // Back-to-back loads each pulse load_valid.
    @(posedge clk); #1;
    setReq(1, 0, 2'b10, 0, 32'h10, 32'h0);
    @(posedge clk); #1;
    setReq(1, 0, 2'b00, 0, 32'h14, 32'h0);
    @(negedge clk);
    checkBit("b2b_lv1", load_valid, 1'b1);
    check("b2b_ld1", load_data, 32'hCAFE1234);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkBit("b2b_lv2", load_valid, 1'b1);
    check("b2b_ld2", load_data, 32'h000000DE);
    @(posedge clk); #1;
    @(negedge clk);
    checkBit("b2b_lv_drop", load_valid, 1'b0);

    // Reset during the RMW write cycle aborts the write.
    @(posedge clk); #1;
    setReq(1, 1, 2'b00, 0, 32'h10, 32'h00000055);
    @(negedge clk);
    checkBit("rstrmw_c1_stall", stall, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkBit("rstrmw_dm_write", dm_write, 1'b0);
    checkBit("rstrmw_dm_read", dm_read, 1'b0);
    checkBit("rstrmw_stall", stall, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("rstrmw_mem", mem[4], 32'hCAFE1234);
    check("rstrmw_load_data", load_data, 32'h0);
    checkBit("rstrmw_load_valid", load_valid, 1'b0);
    checkBit("rstrmw_fault", fault, 1'b0);
    checkBit("rstrmw_dm_write_after", dm_write, 1'b0);
    checkBit("rstrmw_stall_after", stall, 1'b0);

    // After reset the unit is back in IDLE and serves a load.
    @(posedge clk); #1;
    setReq(1, 0, 2'b10, 0, 32'h10, 32'h0);
    @(negedge clk);
    checkBit("post_rst_dm_read", dm_read, 1'b1);
    checkBit("post_rst_dm_write", dm_write, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkBit("post_rst_lv", load_valid, 1'b1);
    check("post_rst_ld", load_data, 32'hCAFE1234);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
